// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit register with clock enable and eight modes
// (hold, load, shift left/right, rotate left/right, clear, invert). A shift
// counter saturating at WIDTH flags a complete serialize/deserialize pass.
module universal_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       enIn,
  input  logic [2:0]                 modeIn,
  input  logic [WIDTH-1:0]           dIn,
  input  logic                       serialIn,
  output logic [WIDTH-1:0]           qOut,
  output logic [WIDTH-1:0]           qNotOut,
  output logic                       serialOut,
  output logic [$clog2(WIDTH+1)-1:0] shiftCntOut,
  output logic                       doneOut
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROL    = 3'b100,
    MODE_ROR    = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_INVERT = 3'b111
  } modeT;

  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] qNotReg;
  logic [CW-1:0]    cntReg;
  logic             dirLeft;

  logic [WIDTH-1:0] qNext;
  logic [CW-1:0]    cntNext;
  logic [CW-1:0]    cntInc;
  logic             dirNext;

  // Saturating increment used by every shift/rotate mode.
  always_comb begin
    cntInc = cntReg;
    if (cntReg != CNT_MAX) begin
      cntInc = cntReg + CW'(1);
    end
  end

  // Next-state selection; modeIn is only looked at when enabled, so an
  // undriven mode bus cannot leak X into the register while disabled.
  always_comb begin
    qNext   = qReg;
    cntNext = cntReg;
    dirNext = dirLeft;
    if (enIn) begin
      unique case (modeT'(modeIn))
        MODE_HOLD: begin
        end
        MODE_LOAD: begin
          qNext   = dIn;
          cntNext = '0;
        end
        MODE_SHL: begin
          qNext   = {qReg[WIDTH-2:0], serialIn};
          dirNext = 1'b1;
          cntNext = cntInc;
        end
        MODE_SHR: begin
          qNext   = {serialIn, qReg[WIDTH-1:1]};
          dirNext = 1'b0;
          cntNext = cntInc;
        end
        MODE_ROL: begin
          qNext   = {qReg[WIDTH-2:0], qReg[WIDTH-1]};
          dirNext = 1'b1;
          cntNext = cntInc;
        end
        MODE_ROR: begin
          qNext   = {qReg[0], qReg[WIDTH-1:1]};
          dirNext = 1'b0;
          cntNext = cntInc;
        end
        MODE_CLEAR: begin
          qNext   = RESET_VALUE;
          cntNext = '0;
          dirNext = 1'b1;
        end
        MODE_INVERT: begin
          qNext = ~qReg;
        end
        default: begin
        end
      endcase
    end
  end

  // State register; the complement is stored alongside q so both change together.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      qReg    <= RESET_VALUE;
      qNotReg <= ~RESET_VALUE;
      cntReg  <= '0;
      dirLeft <= 1'b1;
    end else begin
      qReg    <= qNext;
      qNotReg <= ~qNext;
      cntReg  <= cntNext;
      dirLeft <= dirNext;
    end
  end

  assign qOut        = qReg;
  assign qNotOut     = qNotReg;
  assign shiftCntOut = cntReg;
  assign serialOut   = dirLeft ? qReg[WIDTH-1] : qReg[0];
  assign doneOut     = (cntReg == CNT_MAX);

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register with enable and eight operating modes.
- Modes: hold, parallel load, shift left/right with serial input, rotate left/right, synchronous clear, invert.
- A shift counter with a done flag supports serializer/deserializer use.
- Sits in the base_components library as a building block for serial interfaces and data-path staging.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into qOut on reset and on the CLEAR mode.

Ports:
- clkIn  input  1  clock; all state updates on its rising edge.
- rstIn  input  1  asynchronous, active-low reset.
- enIn  input  1  clock enable; when 0, all state holds regardless of modeIn.
- modeIn  input  3  operation select; encoding given under Behaviour.
- dIn  input  WIDTH  parallel load data.
- serialIn  input  1  bit shifted into the vacated end on SHL/SHR.
- qOut  output  WIDTH  register contents.
- qNotOut  output  WIDTH  bitwise complement of qOut; registered in lock-step with qOut.
- serialOut  output  1  qOut[WIDTH-1] when dirFlag=left, qOut[0] when dirFlag=right.
- shiftCntOut  output  $clog2(WIDTH+1)  number of shift/rotate operations since the last load/clear; saturates at WIDTH.
- doneOut  output  1  high while shiftCntOut == WIDTH.

Behaviour:
- Reset (rstIn=0, asynchronous, independent of clkIn):
  - qOut=RESET_VALUE, qNotOut=~RESET_VALUE.
  - shiftCnt=0, dirFlag=left, doneOut=0.
- Reset release takes effect on the first rising clkIn with rstIn=1.
- Reset asserted mid-operation immediately discards any shift in progress.
- On rising clkIn with rstIn=1 and enIn=1, modeIn selects the operation:
  - 000 HOLD: no change to any state.
  - 001 LOAD: q<=dIn; shiftCnt<=0; dirFlag unchanged.
  - 010 SHL: q<={q[WIDTH-2:0],serialIn}; dirFlag<=left; shiftCnt increments.
  - 011 SHR: q<={serialIn,q[WIDTH-1:1]}; dirFlag<=right; shiftCnt increments.
  - 100 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}; dirFlag<=left; shiftCnt increments.
  - 101 ROR: q<={q[0],q[WIDTH-1:1]}; dirFlag<=right; shiftCnt increments.
  - 110 CLEAR: q<=RESET_VALUE; shiftCnt<=0; dirFlag<=left.
  - 111 INVERT: q<=~q; shiftCnt and dirFlag unchanged.
- enIn=0: q, qNot, shiftCnt and dirFlag all hold; modeIn and serialIn are ignored.
- Latency: one clock from enable/mode sample to updated qOut.
  - serialOut and doneOut are combinational from registered state only (no input-to-output combinational path).
- Counter saturation: shiftCnt stops at WIDTH; further shifts/rotates still move data, but the count stays at WIDTH and doneOut stays high.
- LOAD or CLEAR in the same cycle as doneOut=1: shiftCnt<=0, doneOut falls in the next cycle.
- Direction change mid-sequence (SHL then SHR) is not restarted: the counter keeps incrementing and serialOut follows the new dirFlag from the next cycle.
- qNotOut == ~qOut holds at every observable point, including during reset.
- No X propagation from modeIn when enIn=0.

Test Plan:
- Reset and async check:
  - Stimulus: WIDTH=8; assert rstIn=0 between clock edges while qOut=8'hA5.
  - Required: qOut=8'h00 and qNotOut=8'hFF before the next edge; shiftCntOut=0, doneOut=0.
- Load then serialize left:
  - Stimulus: LOAD dIn=8'hB4, then 8 cycles of SHL with serialIn=0.
  - Required: serialOut sequence before each shift = 1,0,1,1,0,1,0,0; final qOut=8'h00; doneOut rises after the 8th shift; shiftCntOut stays 8 on a 9th shift.
- Deserialize right:
  - Stimulus: CLEAR, then 8 cycles of SHR with serialIn = 1,1,0,0,1,0,1,0.
  - Required: qOut=8'h53; doneOut=1.
- Rotate and invert:
  - Stimulus: LOAD 8'h81, ROL, ROR, ROR, INVERT.
  - Required: qOut goes 8'h03, 8'h81, 8'hC0, then 8'h3F; shiftCntOut=3 after the last ROR and still 3 after INVERT.
- Enable gating:
  - Stimulus: LOAD 8'h5A, then enIn=0 for 4 cycles while cycling modeIn through all 8 codes with serialIn toggling.
  - Required: qOut stays 8'h5A and shiftCntOut stays 0 throughout.
- Reset mid-sequence and saturation restart:
  - Stimulus: with doneOut=1, issue LOAD 8'hFF; then 3 SHL; then pulse rstIn=0.
  - Required: shiftCntOut goes 0 then 3; after reset, qOut=8'h00, shiftCntOut=0, serialOut=qOut[7]=0 (dirFlag=left).
